// File: rtl/crossing_arbiter.sv
// Level-crossing arbiter: grants one of two tracks a green signal behind a lowered barrier.
// Latency: CLOSING lasts CLOSE_CYC cycles before a green; CLEAR lasts CLEAR_CYC cycles.
// Backpressure: none. V0/V1 are levels, so a waiting train keeps requesting until it is served.
//
// Ports:
//   clk            rising-edge system clock
//   reset          asynchronous active-low reset
//   V0, V1         approach sensors for track 0 / track 1 (1 = train requesting)
//   E              exit sensor (1 = granted train has left the crossing)
//   B              barrier command (1 = lowered)
//   T0, T1         track signals (1 = green)
//   last           track of the most recent grant
//   status         current state code
//   fault          watchdog fault latched (terminal until reset)

module crossing_arbiter #(
    parameter int CLOSE_CYC = 8,
    parameter int CLEAR_CYC = 4,
    parameter int TMO_CYC   = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       V0,
    input  logic       V1,
    input  logic       E,
    output logic       B,
    output logic       T0,
    output logic       T1,
    output logic       last,
    output logic [2:0] status,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        CLOSING = 3'b001,
        GRANT   = 3'b010,
        CLEAR   = 3'b011,
        FAULT   = 3'b100
    } state_t;

    // Counters run from N-1 down to 0 so that each timed state lasts exactly N cycles.
    localparam logic [7:0] CLOSE_LD = 8'(CLOSE_CYC - 1);
    localparam logic [7:0] CLEAR_LD = 8'(CLEAR_CYC - 1);
    localparam logic [7:0] TMO_LD   = 8'(TMO_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic       any_req;
    logic       pick;

    assign any_req = V0 | V1;

    // Track choice: a lone requester wins; on a tie, alternate away from the last grant.
    always_comb begin
        pick = V1;
        if (V0 && V1) begin
            pick = ~last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d   = pick;
                    last_d  = pick;
                    cnt_d   = CLOSE_LD;
                    state_d = CLOSING;
                end
            end
            CLOSING: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = TMO_LD;
                    state_d = GRANT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GRANT: begin
                // An exit on the same edge as the timeout wins: the train did leave.
                if (E) begin
                    cnt_d   = CLEAR_LD;
                    state_d = CLEAR;
                end else if (cnt_q == 8'd0) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            CLEAR: begin
                if (cnt_q == 8'd0) begin
                    if (any_req) begin
                        // Barrier is already down, so a waiting train goes straight to green.
                        sel_d   = pick;
                        last_d  = pick;
                        cnt_d   = TMO_LD;
                        state_d = GRANT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Moore outputs. Greens are only ever decoded from GRANT, which always has B=1,
    // so both-green and green-with-barrier-up are structurally impossible.
    always_comb begin
        B     = 1'b1;
        T0    = 1'b0;
        T1    = 1'b0;
        fault = 1'b0;
        case (state_q)
            IDLE:    B = 1'b0;
            GRANT: begin
                T0 = ~sel_q;
                T1 = sel_q;
            end
            FAULT:   fault = 1'b1;
            default: ;
        endcase
    end

    assign status = state_q;
    assign last   = last_q;

endmodule

// File: tb/tb_crossing_arbiter.sv
module tb_crossing_arbiter;

    logic       clk;
    logic       reset;
    logic       V0, V1, E;
    logic       B, T0, T1, last, fault;
    logic [2:0] status;

    int pass_cnt;
    int total_cnt;

    crossing_arbiter #(
        .CLOSE_CYC(8),
        .CLEAR_CYC(4),
        .TMO_CYC  (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .V0    (V0),
        .V1    (V1),
        .E     (E),
        .B     (B),
        .T0    (T0),
        .T1    (T1),
        .last  (last),
        .status(status),
        .fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic       v1;
        logic       e;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Output vector layout: {B, T0, T1, status[2:0], last, fault}
    function automatic logic [7:0] mk(logic b, logic t0, logic t1, logic [2:0] st,
                                      logic lst, logic f);
        return {b, t0, t1, st, lst, f};
    endfunction

    function automatic logic [7:0] outs();
        return {B, T0, T1, status, last, fault};
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b expected %b  ({B,T0,T1,status,last,fault})",
                     name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v0, input logic v1, input logic e, input logic [7:0] exp);
        vec_t v;
        v.v0  = v0;
        v.v1  = v1;
        v.e   = e;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    // Reset applied away from the clock edge; outputs checked while reset is held.
    task automatic do_reset(input string name);
        #2;
        reset = 1'b0;
        V0    = 1'b0;
        V1    = 1'b0;
        E     = 1'b0;
        #1;
        chk(name, outs(), mk(0, 0, 0, 3'd0, 1, 0));
        step();
        step();
        reset = 1'b1;
    endtask

    logic [7:0] idle_l1, idle_l0, cls0, gr0, clr0;
    logic [7:0] snap;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        V0        = 1'b0;
        V1        = 1'b0;
        E         = 1'b0;

        idle_l1 = mk(0, 0, 0, 3'd0, 1, 0);
        idle_l0 = mk(0, 0, 0, 3'd0, 0, 0);
        cls0    = mk(1, 0, 0, 3'd1, 0, 0);
        gr0     = mk(1, 1, 0, 3'd2, 0, 0);
        clr0    = mk(1, 0, 0, 3'd3, 0, 0);

        // Single grant on track 0: E ignored in IDLE/CLOSING, V1 in CLOSING does not
        // steal the grant, exact 8-cycle CLOSING, exact 4-cycle CLEAR, back to IDLE.
        add(0, 0, 1, idle_l1);
        add(0, 0, 0, idle_l1);
        add(1, 0, 0, cls0);     // edge n
        add(1, 0, 1, cls0);
        add(0, 1, 0, cls0);
        add(0, 0, 1, cls0);
        add(1, 1, 0, cls0);
        add(0, 0, 0, cls0);
        add(0, 0, 1, cls0);
        add(0, 0, 0, cls0);     // edge n+7
        add(0, 0, 0, gr0);      // edge n+8
        add(0, 0, 0, gr0);
        add(0, 0, 1, clr0);
        add(1, 0, 0, clr0);
        add(0, 0, 0, clr0);
        add(0, 0, 0, clr0);
        add(0, 0, 0, idle_l0);

        do_reset("reset_a");
        foreach (vecs[i]) begin
            V0 = vecs[i].v0;
            V1 = vecs[i].v1;
            E  = vecs[i].e;
            step();
            chk($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
        end
        V0 = 1'b0; V1 = 1'b0; E = 1'b0;

        // Tie from reset: track 0 first, then round robin straight from CLEAR to GRANT.
        do_reset("reset_b");
        V0 = 1'b1;
        V1 = 1'b1;
        step();
        chk("tie_closing", outs(), cls0);
        for (int i = 0; i < 7; i++) step();
        chk("tie_closing_end", outs(), cls0);
        step();
        chk("tie_grant0", outs(), gr0);
        E = 1'b1;
        step();
        E = 1'b0;
        chk("tie_clear", outs(), clr0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("tie_clear_b%0d", i), outs(), clr0);
        end
        step();
        chk("tie_grant1", outs(), mk(1, 0, 1, 3'd2, 1, 0));
        E = 1'b1;
        step();
        E = 1'b0;
        chk("tie_clear2", outs(), mk(1, 0, 0, 3'd3, 1, 0));
        for (int i = 0; i < 3; i++) step();
        step();
        chk("tie_grant0_again", outs(), gr0);

        // Asynchronous reset in the middle of GRANT, between edges.
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_grant", outs(), idle_l1);
        step();
        reset = 1'b1;
        V0 = 1'b0;
        V1 = 1'b0;

        // Watchdog: GRANT for 20 cycles with no exit, then terminal FAULT.
        do_reset("reset_c");
        V1 = 1'b1;
        step();
        V1 = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("wd_grant", outs(), mk(1, 0, 1, 3'd2, 1, 0));
        for (int i = 0; i < 19; i++) step();
        chk("wd_grant_last", outs(), mk(1, 0, 1, 3'd2, 1, 0));
        step();
        chk("wd_fault", outs(), mk(1, 0, 0, 3'd4, 1, 1));
        for (int i = 0; i < 8; i++) begin
            V0 = i[0];
            V1 = i[1];
            E  = i[2] | i[0];
            step();
            chk($sformatf("fault_hold%0d", i), outs(), mk(1, 0, 0, 3'd4, 1, 1));
        end
        #2;
        reset = 1'b0;
        #1;
        chk("fault_cleared", outs(), idle_l1);
        step();
        reset = 1'b1;

        // Random stimulus with safety invariants on every cycle.
        do_reset("reset_d");
        for (int i = 0; i < 400; i++) begin
            V0 = ($urandom_range(0, 3) == 0);
            V1 = ($urandom_range(0, 3) == 0);
            E  = ($urandom_range(0, 3) == 0);
            step();
            chk("rand_excl", {7'd0, T0 & T1}, 8'd0);
            chk("rand_green_barrier", {7'd0, (T0 | T1) & ~B}, 8'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
